mem_access_unit: RTL and testbench

//  Initiator side of the data-memory port: turns CPU load/store requests into word-wide

---
 rtl/mem_access_unit.sv | 135 +++++++++++++
 tb/tb_mem_access_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store initiator for a word-only data memory.
// Sub-word stores use read-modify-write; loads are lane-extracted and sign/zero extended.
module mem_access_unit #(
    parameter int unsigned MEM_BYTES = 65536
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        memWrite,
    output logic [31:0] address,
    output logic [31:0] writeData,
    input  logic [31:0] readData
);

    localparam logic [31:0] MemLimit = 32'(MEM_BYTES);

    typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

    state_t      state;
    logic        reqWe;
    logic        reqUnsigned;
    logic [1:0]  reqSize;
    logic [1:0]  reqLane;
    logic [31:0] reqWdata;
    logic        accept;
    logic        reqBad;

    function automatic logic [31:0] extractLoad(input logic [31:0] word, input logic [1:0] lane,
                                                input logic [1:0] size, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (size)
            2'd0:    extractLoad = uns ? {24'b0, b} : {{24{b[7]}}, b};
            2'd1:    extractLoad = uns ? {16'b0, h} : {{16{h[15]}}, h};
            default: extractLoad = word;
        endcase
    endfunction

    function automatic logic [31:0] mergeStore(input logic [31:0] word, input logic [1:0] lane,
                                               input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] res;
        res = word;
        case (size)
            2'd0:    res[{lane, 3'b000} +: 8] = wdata[7:0];
            2'd1:    res[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            default: res = wdata;
        endcase
        return res;
    endfunction

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign reqBad    = (req_size == 2'd3)
                    || (req_size == 2'd1 && req_addr[0])
                    || (req_size == 2'd2 && req_addr[1:0] != 2'b00)
                    || (req_addr >= MemLimit);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            memWrite    <= 1'b0;
            address     <= '0;
            writeData   <= '0;
            resp_valid  <= 1'b0;
            resp_rdata  <= '0;
            resp_err    <= 1'b0;
            reqWe       <= 1'b0;
            reqUnsigned <= 1'b0;
            reqSize     <= '0;
            reqLane     <= '0;
            reqWdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        reqWe       <= req_we;
                        reqUnsigned <= req_unsigned;
                        reqSize     <= req_size;
                        reqLane     <= req_addr[1:0];
                        reqWdata    <= req_wdata;
                        address     <= {req_addr[31:2], 2'b00};
                        if (reqBad) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            state      <= RESP;
                        end else if (req_we && req_size == 2'd2) begin
                            writeData <= req_wdata;
                            memWrite  <= 1'b1;
                            state     <= WR;
                        end else begin
                            state <= RD;
                        end
                    end
                end
                RD: state <= CAP;
                // readData now holds the addressed word
                CAP: begin
                    if (reqWe) begin
                        writeData <= mergeStore(readData, reqLane, reqSize, reqWdata);
                        memWrite  <= 1'b1;
                        state     <= WR;
                    end else begin
                        resp_rdata <= extractLoad(readData, reqLane, reqSize, reqUnsigned);
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                WR: begin
                    memWrite   <= 1'b0;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: word memory model, byte-level reference memory,
// directed cases followed by randomized requests.
module tb_mem_access_unit;

    localparam int unsigned MEM_BYTES = 65536;

    logic        clock = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        memWrite;
    logic [31:0] address;
    logic [31:0] writeData;
    logic [31:0] readData;

    bit [31:0] mem    [0:16383];
    bit [31:0] refMem [0:16383];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int accCnt = 0;
    int respCnt = 0;
    int wrCount = 0;
    int lastAcc = 0;
    int lastWrCyc = 0;
    int lastRespCyc = 0;
    logic [31:0] lastWrAddr = '0;
    logic [31:0] lastWrData = '0;
    logic [31:0] lastRespData = '0;

    mem_access_unit #(.MEM_BYTES(MEM_BYTES)) dut (
        .clock(clock), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .memWrite(memWrite), .address(address),
        .writeData(writeData), .readData(readData)
    );

    always #5 clock = ~clock;

    // Synchronous word memory: registered read, one cycle after the address is presented.
    always @(posedge clock) begin
        if (memWrite) mem[address[15:2]] <= writeData;
        readData <= mem[address[15:2]];
    end

    always @(posedge clock) begin
        cyc++;
        if (req_valid && req_ready) begin accCnt++; lastAcc = cyc; end
        if (memWrite) begin wrCount++; lastWrCyc = cyc; lastWrAddr = address; lastWrData = writeData; end
        if (resp_valid) begin respCnt++; lastRespCyc = cyc; lastRespData = resp_rdata; end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference behaviour computed byte by byte over refMem.
    task automatic modelReq(input logic we, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            output logic expErr, output logic [31:0] expData, output int expLat);
        int unsigned n, a, sh;
        logic [31:0] v;
        n = 1 << size;
        expErr = (size == 2'd3) || (addr % n != 0) || (addr >= MEM_BYTES);
        expData = '0;
        if (expErr) begin
            expLat = 1;
        end else if (we) begin
            expLat = (n == 4) ? 2 : 4;
            for (int k = 0; k < int'(n); k++) begin
                a = addr + k;
                sh = 8 * (a % 4);
                refMem[a / 4] = (refMem[a / 4] & ~(32'hFF << sh)) | (((wdata >> (8 * k)) & 32'hFF) << sh);
            end
        end else begin
            expLat = 3;
            v = '0;
            for (int k = 0; k < int'(n); k++) begin
                a = addr + k;
                v = v | (((refMem[a / 4] >> (8 * (a % 4))) & 32'hFF) << (8 * k));
            end
            if (!uns && n < 4 && v[8 * n - 1]) v = v | (32'hFFFFFFFF << (8 * n));
            expData = v;
        end
    endtask

    task automatic waitReady(input string tag);
        int n;
        n = 0;
        @(negedge clock);
        while (!req_ready && n < 20) begin @(negedge clock); n++; end
        check({tag, "_rdy"}, 32'(req_ready), 32'd1);
    endtask

    task automatic runReq(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input string tag, output logic [31:0] got);
        logic expErr;
        logic [31:0] expData;
        int expLat, lat, wrBefore;
        modelReq(we, size, uns, addr, wdata, expErr, expData, expLat);
        waitReady(tag);
        req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        wrBefore = wrCount;
        @(posedge clock); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 12) begin @(posedge clock); #1; lat++; end
        got = resp_rdata;
        check({tag, "_lat"}, 32'(lat), 32'(expLat));
        check({tag, "_err"}, 32'(resp_err), 32'(expErr));
        check({tag, "_rdata"}, resp_rdata, expData);
        check({tag, "_wrcnt"}, 32'(wrCount - wrBefore), (we && !expErr) ? 32'd1 : 32'd0);
        if (we && !expErr) begin
            check({tag, "_wrcyc"}, 32'(lastWrCyc - lastAcc), 32'(expLat - 1));
            check({tag, "_wraddr"}, lastWrAddr, {addr[31:2], 2'b00});
        end
        if (addr < MEM_BYTES) check({tag, "_mem"}, mem[addr[15:2]], refMem[addr[15:2]]);
        @(posedge clock); #1;
        check({tag, "_pulse"}, {resp_valid, resp_err, 30'b0} | resp_rdata, 32'd0);
    endtask

    logic [31:0] got;
    logic        bErr;
    logic [31:0] bData;
    int          bLat, swAcc, accBefore, respBefore, wrBefore, n;
    logic [1:0]  rSize;
    logic [31:0] rAddr;

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0;
        #12;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_memWrite", 32'(memWrite), 32'd0);
        check("rst_address", address, 32'd0);
        check("rst_writeData", writeData, 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        @(negedge clock); rst_n = 1'b1;

        runReq(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, "sw10", got);
        check("sw10_wdata", lastWrData, 32'hDEADBEEF);
        runReq(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, "lw10", got);
        check("lw10_val", got, 32'hDEADBEEF);

        runReq(1'b1, 2'd2, 1'b0, 32'h20, 32'h80FF7F01, "sw20", got);
        runReq(1'b0, 2'd0, 1'b0, 32'h21, 32'h0, "lb21", got);
        check("lb21_val", got, 32'h0000007F);
        runReq(1'b0, 2'd0, 1'b0, 32'h22, 32'h0, "lb22", got);
        check("lb22_val", got, 32'hFFFFFFFF);
        runReq(1'b0, 2'd0, 1'b1, 32'h23, 32'h0, "lbu23", got);
        check("lbu23_val", got, 32'h00000080);
        runReq(1'b0, 2'd1, 1'b0, 32'h22, 32'h0, "lh22", got);
        check("lh22_val", got, 32'hFFFF80FF);
        runReq(1'b0, 2'd1, 1'b1, 32'h20, 32'h0, "lhu20", got);
        check("lhu20_val", got, 32'h00007F01);

        runReq(1'b1, 2'd2, 1'b0, 32'h30, 32'h11223344, "sw30", got);
        runReq(1'b1, 2'd0, 1'b0, 32'h31, 32'h000000AA, "sb31", got);
        check("sb31_wdata", lastWrData, 32'h1122AA44);
        runReq(1'b1, 2'd1, 1'b0, 32'h32, 32'h0000BEEF, "sh32", got);
        check("sh32_wdata", lastWrData, 32'hBEEFAA44);
        runReq(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, "lw30", got);
        check("lw30_val", got, 32'hBEEFAA44);

        runReq(1'b0, 2'd2, 1'b0, 32'h13, 32'h0, "lw13", got);
        runReq(1'b1, 2'd1, 1'b0, 32'h11, 32'h5555, "sh11", got);
        runReq(1'b0, 2'd3, 1'b0, 32'h14, 32'h0, "size3", got);
        runReq(1'b0, 2'd2, 1'b0, MEM_BYTES, 32'h0, "lwoor", got);
        check("err_mem10", mem[4], 32'hDEADBEEF);

        // Reset while the sub-word store is in its read phase.
        runReq(1'b1, 2'd2, 1'b0, 32'h40, 32'h11223344, "sw40", got);
        waitReady("abort");
        req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0; req_addr = 32'h41; req_wdata = 32'h55;
        req_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        respBefore = respCnt; wrBefore = wrCount;
        rst_n = 1'b0;
        #1;
        check("abort_memWrite", 32'(memWrite), 32'd0);
        check("abort_ready_in_rst", 32'(req_ready), 32'd1);
        repeat (3) @(posedge clock);
        @(negedge clock); rst_n = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        check("abort_no_resp", 32'(respCnt - respBefore), 32'd0);
        check("abort_no_write", 32'(wrCount - wrBefore), 32'd0);
        check("abort_ready", 32'(req_ready), 32'd1);
        runReq(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, "lw40", got);
        check("lw40_val", got, 32'h11223344);

        // Back-to-back with req_valid held high across both requests.
        modelReq(1'b1, 2'd2, 1'b0, 32'h50, 32'hCAFEF00D, bErr, bData, bLat);
        modelReq(1'b0, 2'd2, 1'b0, 32'h50, 32'h0, bErr, bData, bLat);
        waitReady("b2b");
        accBefore = accCnt; respBefore = respCnt;
        req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h50; req_wdata = 32'hCAFEF00D;
        req_valid = 1'b1;
        @(posedge clock); #1;
        swAcc = lastAcc;
        req_we = 1'b0; req_wdata = 32'h0;
        n = 0;
        while (accCnt < accBefore + 2 && n < 12) begin @(posedge clock); #1; n++; end
        req_valid = 1'b0;
        check("b2b_acc_gap", 32'(lastAcc - swAcc), 32'd3);
        n = 0;
        while (respCnt < respBefore + 2 && n < 12) begin @(posedge clock); #1; n++; end
        check("b2b_resp_cnt", 32'(respCnt - respBefore), 32'd2);
        check("b2b_resp_lat", 32'(lastRespCyc - lastAcc), 32'd3);
        check("b2b_rdata", lastRespData, bData);

        for (int i = 0; i < 40; i++) begin
            n = $urandom_range(0, 9);
            rSize = (n < 3) ? 2'd0 : (n < 6) ? 2'd1 : (n < 9) ? 2'd2 : 2'd3;
            rAddr = 32'h100 + $urandom_range(0, 63);
            if ($urandom_range(0, 3) != 0 && rSize != 2'd3) rAddr = rAddr & ~((32'd1 << rSize) - 32'd1);
            if ($urandom_range(0, 9) == 0) rAddr = MEM_BYTES + $urandom_range(0, 255);
            runReq(1'($urandom_range(0, 1)), rSize, 1'($urandom_range(0, 1)), rAddr, $urandom, "rnd", got);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
